// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 7/8 data bits LSB first, optional even parity,
// 1 or 2 stop bits, paced by a 16x tick divider selected per frame.
module uart_transmitter #(
   parameter int DIV_LO = 326,
   parameter int DIV_HI = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] data,
   input  logic       dnum,
   input  logic       snum,
   input  logic       par,
   input  logic       bd_rate,
   output logic       dout,
   output logic       tx_ready,
   output logic       tx_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   function automatic logic even_parity(input logic [7:0] bits);
      return ^bits;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] div_cnt_q, div_cnt_d;
   logic [15:0] div_q, div_d;
   logic [3:0]  tick_cnt_q, tick_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        par_bit_q, par_bit_d;
   logic        dnum_q, dnum_d;
   logic        snum_q, snum_d;
   logic        par_q, par_d;
   logic        dout_q, dout_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic        tick_s;
   logic        bit_end_s;
   logic [2:0]  last_idx_s;

   // Next-state, tick generation and registered-output computation
   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      div_d      = div_q;
      tick_cnt_d = tick_cnt_q;
      bit_idx_d  = bit_idx_q;
      shreg_d    = shreg_q;
      par_bit_d  = par_bit_q;
      dnum_d     = dnum_q;
      snum_d     = snum_q;
      par_d      = par_q;
      dout_d     = dout_q;
      ready_d    = ready_q;
      done_d     = 1'b0;
      tick_s     = (div_cnt_q == (div_q - 16'd1));
      bit_end_s  = tick_s && (tick_cnt_q == 4'd15);
      last_idx_s = dnum_q ? 3'd7 : 3'd6;

      // Divider only runs while a frame is in flight
      if (state_q == S_IDLE) begin
         div_cnt_d  = 16'd0;
         tick_cnt_d = 4'd0;
      end else if (tick_s) begin
         div_cnt_d  = 16'd0;
         tick_cnt_d = tick_cnt_q + 4'd1;
      end else begin
         div_cnt_d  = div_cnt_q + 16'd1;
      end

      case (state_q)
         S_IDLE: begin
            dout_d  = 1'b1;
            ready_d = 1'b1;
            if (tx_start && ready_q) begin
               state_d    = S_START;
               dout_d     = 1'b0;
               ready_d    = 1'b0;
               div_cnt_d  = 16'd0;
               tick_cnt_d = 4'd0;
               div_d      = bd_rate ? 16'(DIV_HI) : 16'(DIV_LO);
               shreg_d    = data;
               par_bit_d  = even_parity(dnum ? data : {1'b0, data[6:0]});
               dnum_d     = dnum;
               snum_d     = snum;
               par_d      = par;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (bit_end_s) begin
               state_d   = S_DATA;
               dout_d    = shreg_q[0];
               shreg_d   = {1'b0, shreg_q[7:1]};
               bit_idx_d = 3'd0;
            end else begin
               state_d = S_START;
            end
         end
         S_DATA: begin
            if (bit_end_s) begin
               if (bit_idx_q == last_idx_s) begin
                  bit_idx_d = 3'd0;
                  if (par_q) begin
                     state_d = S_PARITY;
                     dout_d  = par_bit_q;
                  end else begin
                     state_d = S_STOP;
                     dout_d  = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  dout_d    = shreg_q[0];
                  shreg_d   = {1'b0, shreg_q[7:1]};
               end
            end else begin
               state_d = S_DATA;
            end
         end
         S_PARITY: begin
            if (bit_end_s) begin
               state_d   = S_STOP;
               dout_d    = 1'b1;
               bit_idx_d = 3'd0;
            end else begin
               state_d = S_PARITY;
            end
         end
         S_STOP: begin
            // bit_idx counts completed stop bits when two are requested
            if (bit_end_s) begin
               if (snum_q && (bit_idx_q == 3'd0)) begin
                  bit_idx_d = 3'd1;
               end else begin
                  state_d = S_IDLE;
                  dout_d  = 1'b1;
                  ready_d = 1'b1;
                  done_d  = 1'b1;
               end
            end else begin
               state_d = S_STOP;
            end
         end
         default: begin
            state_d = S_IDLE;
            dout_d  = 1'b1;
            ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         div_cnt_q  <= 16'd0;
         div_q      <= 16'd0;
         tick_cnt_q <= 4'd0;
         bit_idx_q  <= 3'd0;
         shreg_q    <= 8'd0;
         par_bit_q  <= 1'b0;
         dnum_q     <= 1'b0;
         snum_q     <= 1'b0;
         par_q      <= 1'b0;
         dout_q     <= 1'b1;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         div_q      <= div_d;
         tick_cnt_q <= tick_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shreg_q    <= shreg_d;
         par_bit_q  <= par_bit_d;
         dnum_q     <= dnum_d;
         snum_q     <= snum_d;
         par_q      <= par_d;
         dout_q     <= dout_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   assign dout     = dout_q;
   assign tx_ready = ready_q;
   assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: per-cycle frame model plus
// hand-computed mid-bit samples and frame lengths.
module tb_uart_transmitter;
   localparam int DIV_LO_T = 3;
   localparam int DIV_HI_T = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] data = 8'h00;
   logic       dnum = 1'b1;
   logic       snum = 1'b0;
   logic       par = 1'b0;
   logic       bd_rate = 1'b1;
   logic       dout;
   logic       tx_ready;
   logic       tx_done;

   always #5 clk = ~clk;

   uart_transmitter #(.DIV_LO(DIV_LO_T), .DIV_HI(DIV_HI_T)) dut (
      .clk(clk), .rst(rst), .tx_start(tx_start), .data(data), .dnum(dnum),
      .snum(snum), .par(par), .bd_rate(bd_rate), .dout(dout),
      .tx_ready(tx_ready), .tx_done(tx_done)
   );

   int chk = 0;
   int err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame model: the line is a list of bits, each held for bt cycles after accept
   logic m_dout = 1'b1;
   logic m_ready = 1'b1;
   logic m_done = 1'b0;
   bit   m_busy = 1'b0;
   int   m_k = 0;
   int   m_len = 0;
   int   m_bt = 1;
   logic m_p;
   logic m_frame [0:11];

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0; m_dout = 1'b1; m_ready = 1'b1; m_done = 1'b0;
      end else if (m_ready && tx_start) begin
         m_len = 0;
         m_p = 1'b0;
         m_frame[m_len] = 1'b0; m_len++;
         for (int i = 0; i < (dnum ? 8 : 7); i++) begin
            m_frame[m_len] = data[i]; m_p = m_p ^ data[i]; m_len++;
         end
         if (par) begin m_frame[m_len] = m_p; m_len++; end
         m_frame[m_len] = 1'b1; m_len++;
         if (snum) begin m_frame[m_len] = 1'b1; m_len++; end
         m_bt = 16 * (bd_rate ? DIV_HI_T : DIV_LO_T);
         m_busy = 1'b1; m_k = 0;
         m_dout = m_frame[0]; m_ready = 1'b0; m_done = 1'b0;
      end else if (m_busy) begin
         m_k++;
         if (m_k == m_len * m_bt) begin
            m_busy = 1'b0; m_dout = 1'b1; m_ready = 1'b1; m_done = 1'b1;
         end else begin
            m_dout = m_frame[m_k / m_bt]; m_done = 1'b0;
         end
      end else begin
         m_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("dout", 32'(dout), 32'(m_dout));
         check("tx_ready", 32'(tx_ready), 32'(m_ready));
         check("tx_done", 32'(tx_done), 32'(m_done));
      end
   end

   // Called at a negedge; returns cycles until tx_done is seen (-1 on timeout)
   task automatic wait_done(output int c_out);
      c_out = -1;
      for (int c = 0; c < 3000; c++) begin
         if (tx_done === 1'b1) begin c_out = c; break; end
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic dn, input logic sn,
                             input logic pa, input logic bd, input int nbits, input int bt,
                             output logic [11:0] got, output int done_c);
      data = d; dnum = dn; snum = sn; par = pa; bd_rate = bd;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      got = 12'd0;
      done_c = -1;
      for (int c = 0; c < 3000; c++) begin
         if ((c % bt) == (bt / 2) && (c / bt) < nbits) got[c / bt] = dout;
         if (tx_done === 1'b1) begin done_c = c; break; end
         @(negedge clk);
      end
   endtask

   logic [11:0] got;
   int dc;

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_dout", 32'(dout), 32'd1);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_done", 32'(tx_done), 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_dout", 32'(dout), 32'd1);
      check("idle_ready", 32'(tx_ready), 32'd1);

      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 10, 32, got, dc);
      check("a5_bits", 32'(got), 32'h34A);
      check("a5_len", dc, 32'd320);
      check("a5_ready", 32'(tx_ready), 32'd1);
      repeat (3) @(negedge clk);

      send_frame(8'h83, 1'b0, 1'b1, 1'b1, 1'b1, 11, 32, got, dc);
      check("83_bits", 32'(got), 32'h606);
      check("83_len", dc, 32'd352);
      repeat (3) @(negedge clk);

      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 10, 48, got, dc);
      check("5a_slow_bits", 32'(got), 32'h2B4);
      check("5a_slow_len", dc, 32'd480);
      repeat (3) @(negedge clk);

      data = 8'h55; dnum = 1'b1; snum = 1'b0; par = 1'b0; bd_rate = 1'b1;
      tx_start = 1'b1;
      @(negedge clk);
      data = 8'h0F;
      wait_done(dc);
      check("b2b_first_len", dc, 32'd320);
      @(negedge clk);
      check("b2b_start_bit", 32'(dout), 32'd0);
      check("b2b_busy", 32'(tx_ready), 32'd0);
      tx_start = 1'b0;
      wait_done(dc);
      check("b2b_second_len", dc, 32'd320);
      repeat (3) @(negedge clk);

      data = 8'h00; tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (100) @(negedge clk);
      data = 8'hFF; tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      wait_done(dc);
      check("ignore_len", dc, 32'd219);
      repeat (3) @(negedge clk);

      data = 8'hA5; tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (4 * 32 + 10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_dout", 32'(dout), 32'd1);
      check("midrst_ready", 32'(tx_ready), 32'd1);
      check("midrst_done", 32'(tx_done), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 10, 32, got, dc);
      check("3c_bits", 32'(got), 32'h278);
      check("3c_len", dc, 32'd320);
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end
endmodule
